// File: rtl/frame_pkg.sv
// Shared constants for the photo-frame design: top-level FSM state codes
// and the default geometry of the frame buffer and its write path.
package frame_pkg;

    // Top-level FSM state codes as seen on i_state
    localparam logic [7:0] ST_IDLE = 8'h01;
    localparam logic [7:0] ST_RX   = 8'h02;

    // Default geometry: RGB444 pixels, 15-bit SPRAM address, 160x120 frame
    localparam int DEF_DW           = 12;
    localparam int DEF_AW           = 15;
    localparam int DEF_FRAME_PIXELS = 19200;
    localparam int DEF_FIFO_DEPTH   = 4;

endpackage

// File: rtl/frame_wr_fifo.sv
// Small synchronous write buffer between the pixel receiver and the SPRAM
// arbiter. Pointers carry an extra wrap bit so that full and empty can be
// told apart without a separate occupancy counter. A flush empties the
// buffer and wins over a push or pop issued in the same cycle.
module frame_wr_fifo #(
    parameter int DW         = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [DW-1:0] push_data,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] head_data
);

    localparam int PW = $clog2(FIFO_DEPTH);

    logic [PW:0]   wr_ptr_r;
    logic [PW:0]   rd_ptr_r;
    logic [DW-1:0] mem_r [FIFO_DEPTH];
    logic          full_s;
    logic          empty_s;
    logic          do_push_s;
    logic          do_pop_s;

    // Full/empty from pointer comparison; qualified push/pop
    always_comb begin
        empty_s   = (wr_ptr_r == rd_ptr_r);
        full_s    = (wr_ptr_r[PW] != rd_ptr_r[PW]) &&
                    (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
        do_pop_s  = pop && !empty_s && !flush;
        do_push_s = push && (!full_s || do_pop_s) && !flush;
    end

    // Read/write pointers with flush back to the empty state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{PW{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{PW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage array, cleared on reset so the head never presents X
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r[PW-1:0]] <= push_data;
        end
    end

    assign full      = full_s;
    assign empty     = empty_s;
    assign head_data = mem_r[rd_ptr_r[PW-1:0]];

endmodule

// File: rtl/spram_frame_wr_arb.sv
// Frame-buffer write path with display-read arbitration for a single-port
// SPRAM. Received pixels are buffered and written to sequential addresses
// in cycles where the display does not read. The SPRAM port is registered,
// so a decision made in cycle N drives the SPRAM in cycle N+1, and read
// data returns to the display two cycles after the request.
module spram_frame_wr_arb
    import frame_pkg::*;
#(
    parameter int         DW           = DEF_DW,
    parameter int         AW           = DEF_AW,
    parameter int         FRAME_PIXELS = DEF_FRAME_PIXELS,
    parameter int         FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter logic [7:0] WR_STATE     = ST_RX
) (
    input  logic          i_clk_sys,
    input  logic          i_rst_n,
    input  logic [7:0]    i_state,
    input  logic          i_rx_valid,
    input  logic [DW-1:0] i_rx_data,
    input  logic          i_frame_start,
    input  logic          i_rd_req,
    input  logic [AW-1:0] i_rd_addr,
    output logic          o_rd_valid,
    output logic [DW-1:0] o_rd_data,
    output logic [AW-1:0] o_spram_addr,
    output logic [DW-1:0] o_spram_wr_data,
    output logic          o_spram_wre,
    input  logic [DW-1:0] i_spram_rd_data,
    output logic [AW-1:0] o_wr_addr,
    output logic          o_frame_done,
    output logic          o_fifo_full,
    output logic          o_overflow
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_PIXELS - 1);

    logic          capture_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [DW-1:0] fifo_head_s;
    logic [AW-1:0] wr_addr_r;
    logic [AW-1:0] spram_addr_r;
    logic [DW-1:0] spram_wr_data_r;
    logic          spram_wre_r;
    logic          frame_done_r;
    logic          overflow_r;
    logic          rd_pend_r;
    logic          rd_valid_r;

    // Arbitration: display reads first, then drain the buffer; a frame
    // restart suppresses the write so flushed data never reaches the SPRAM
    always_comb begin
        capture_s = i_rx_valid && (i_state == WR_STATE) && !i_frame_start;
        if (i_rd_req) begin
            pop_s = 1'b0;
        end else if (!fifo_empty_s && !i_frame_start) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        push_s = capture_s && (!fifo_full_s || pop_s);
        drop_s = capture_s && fifo_full_s && !pop_s;
    end

    frame_wr_fifo #(
        .DW         (DW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_clk_sys),
        .rst_n     (i_rst_n),
        .push      (push_s),
        .pop       (pop_s),
        .flush     (i_frame_start),
        .push_data (i_rx_data),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .head_data (fifo_head_s)
    );

    // Registered SPRAM port; address and data hold when the port is idle
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            spram_addr_r    <= '0;
            spram_wr_data_r <= '0;
            spram_wre_r     <= 1'b0;
            frame_done_r    <= 1'b0;
        end else if (i_rd_req) begin
            spram_addr_r <= i_rd_addr;
            spram_wre_r  <= 1'b0;
            frame_done_r <= 1'b0;
        end else if (pop_s) begin
            spram_addr_r    <= wr_addr_r;
            spram_wr_data_r <= fifo_head_s;
            spram_wre_r     <= 1'b1;
            frame_done_r    <= (wr_addr_r == LAST_ADDR);
        end else begin
            spram_wre_r  <= 1'b0;
            frame_done_r <= 1'b0;
        end
    end

    // Frame write address: advances per written pixel, wraps at frame end
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_addr_r <= '0;
        end else if (i_frame_start) begin
            wr_addr_r <= '0;
        end else if (pop_s) begin
            wr_addr_r <= (wr_addr_r == LAST_ADDR) ? '0 : wr_addr_r + AW'(1);
        end else begin
            wr_addr_r <= wr_addr_r;
        end
    end

    // Sticky dropped-pixel flag, cleared when a new frame starts
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            overflow_r <= 1'b0;
        end else if (i_frame_start) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // Read-return pipeline: port register stage, then SPRAM latency
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_pend_r  <= 1'b0;
            rd_valid_r <= 1'b0;
        end else begin
            rd_pend_r  <= i_rd_req;
            rd_valid_r <= rd_pend_r;
        end
    end

    assign o_spram_addr    = spram_addr_r;
    assign o_spram_wr_data = spram_wr_data_r;
    assign o_spram_wre     = spram_wre_r;
    assign o_frame_done    = frame_done_r;
    assign o_wr_addr       = wr_addr_r;
    assign o_overflow      = overflow_r;
    assign o_fifo_full     = fifo_full_s;
    assign o_rd_valid      = rd_valid_r;
    // SPRAM data is only meaningful in the cycle the read returns
    assign o_rd_data       = rd_valid_r ? i_spram_rd_data : '0;

endmodule

// File: tb/tb_spram_frame_wr_arb.sv
// Bench for spram_frame_wr_arb with a short frame (8 pixels) and a 4-deep
// buffer. A behavioural SPRAM sits on the memory port; a queue-based model
// predicts every output cycle by cycle.
module tb_spram_frame_wr_arb;
    import frame_pkg::*;

    localparam int DW    = 12;
    localparam int AW    = 15;
    localparam int FP    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    state = 8'h00;
    logic          rx_valid = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic          frame_start = 1'b0;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] spram_addr;
    logic [DW-1:0] spram_wr_data;
    logic          spram_wre;
    logic [DW-1:0] spram_q = '0;
    logic [AW-1:0] wr_addr;
    logic          frame_done;
    logic          fifo_full;
    logic          overflow;

    always #5 clk = ~clk;

    spram_frame_wr_arb #(
        .DW(DW), .AW(AW), .FRAME_PIXELS(FP), .FIFO_DEPTH(DEPTH), .WR_STATE(ST_RX)
    ) dut (
        .i_clk_sys(clk), .i_rst_n(rst_n), .i_state(state),
        .i_rx_valid(rx_valid), .i_rx_data(rx_data), .i_frame_start(frame_start),
        .i_rd_req(rd_req), .i_rd_addr(rd_addr),
        .o_rd_valid(rd_valid), .o_rd_data(rd_data),
        .o_spram_addr(spram_addr), .o_spram_wr_data(spram_wr_data),
        .o_spram_wre(spram_wre), .i_spram_rd_data(spram_q),
        .o_wr_addr(wr_addr), .o_frame_done(frame_done),
        .o_fifo_full(fifo_full), .o_overflow(overflow)
    );

    function automatic logic [DW-1:0] init_val(input int i);
        logic [DW-1:0] v;
        v = i[DW-1:0];
        return (i == 5) ? 12'h5A5 : (v ^ 12'h3C3);
    endfunction

    // Behavioural single-port SPRAM: one-cycle read latency
    logic [DW-1:0] spram_mem [0:(1<<AW)-1];
    bit            mem_init_done = 1'b0;
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < (1 << AW); i++) spram_mem[i] <= init_val(i);
            mem_init_done <= 1'b1;
        end else if (spram_wre) begin
            spram_mem[spram_addr] <= spram_wr_data;
        end else begin
            spram_q <= spram_mem[spram_addr];
        end
    end

    // ---------------- reference model state ----------------
    int            n_checks = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            m_q[$];
    int            m_wa = 0;
    bit            m_ovf = 1'b0;
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic          e_wre = 1'b0;
    logic          e_done = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wd = '0;
    logic          e_rv = 1'b0;
    logic [DW-1:0] e_rd = '0;
    logic          prev_rv = 1'b0;
    logic [DW-1:0] prev_rd = '0;
    int            wl_addr[$];
    int            wl_data[$];
    int            wl_done[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic set_in(input logic [7:0] st, input logic v, input logic [DW-1:0] d,
                          input logic fs, input logic rr, input logic [AW-1:0] ra);
        state = st; rx_valid = v; rx_data = d; frame_start = fs; rd_req = rr; rd_addr = ra;
    endtask

    task automatic model_reset();
        m_q.delete(); m_wa = 0; m_ovf = 1'b0;
        e_wre = 1'b0; e_done = 1'b0; e_addr = '0; e_wd = '0;
        e_rv = 1'b0; e_rd = '0; prev_rv = 1'b0; prev_rd = '0;
    endtask

    // One clock: predict from the current inputs, advance, compare everything
    task automatic step();
        bit            cap;
        bit            pop;
        logic          cur_rv;
        logic [DW-1:0] cur_rd;
        cap    = rx_valid && (state == ST_RX) && !frame_start;
        pop    = !rd_req && (m_q.size() > 0) && !frame_start;
        cur_rv = rd_req;
        cur_rd = rd_req ? ref_mem[rd_addr] : '0;
        if (rd_req) begin
            e_addr = rd_addr; e_wre = 1'b0; e_done = 1'b0;
        end else if (pop) begin
            e_addr = AW'(m_wa); e_wd = DW'(m_q[0]); e_wre = 1'b1;
            e_done = (m_wa == FP - 1);
            ref_mem[m_wa] = DW'(m_q[0]);
            void'(m_q.pop_front());
            m_wa = (m_wa + 1) % FP;
        end else begin
            e_wre = 1'b0; e_done = 1'b0;
        end
        if (frame_start) begin
            m_q.delete(); m_wa = 0; m_ovf = 1'b0;
        end
        if (cap) begin
            if (m_q.size() < DEPTH) m_q.push_back(int'(rx_data));
            else m_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
        e_rv = prev_rv; e_rd = prev_rd; prev_rv = cur_rv; prev_rd = cur_rd;
        check("m_wre", 32'(spram_wre), 32'(e_wre));
        check("m_addr", 32'(spram_addr), 32'(e_addr));
        check("m_wdata", 32'(spram_wr_data), 32'(e_wd));
        check("m_done", 32'(frame_done), 32'(e_done));
        check("m_wr_addr", 32'(wr_addr), 32'(m_wa));
        check("m_full", 32'(fifo_full), 32'(m_q.size() == DEPTH));
        check("m_ovf", 32'(overflow), 32'(m_ovf));
        check("m_rd_valid", 32'(rd_valid), 32'(e_rv));
        check("m_rd_data", 32'(rd_data), e_rv ? 32'(e_rd) : 32'd0);
        if (spram_wre) begin
            wl_addr.push_back(int'(spram_addr));
            wl_data.push_back(int'(spram_wr_data));
            wl_done.push_back(int'(frame_done));
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, {rd_valid, rd_data, spram_addr, spram_wr_data, spram_wre},
              32'd0);
        check({name, "_b"}, {wr_addr, frame_done, fifo_full, overflow}, 32'd0);
    endtask

    task automatic wl_clear();
        wl_addr.delete(); wl_data.delete(); wl_done.delete();
    endtask

    typedef struct {
        logic [7:0]    st;
        logic          v;
        logic [DW-1:0] d;
        logic          e_wre;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        logic [AW-1:0] e_wa;
    } vec_t;

    vec_t tbl[5];
    int   done_cnt;

    initial begin
        // Expected outputs are those seen one clock after the row is applied
        tbl[0] = '{ST_RX,   1'b1, 12'h375, 1'b0, 15'd0, 12'h000, 15'd0};
        tbl[1] = '{ST_RX,   1'b0, 12'h000, 1'b1, 15'd0, 12'h375, 15'd1};
        tbl[2] = '{ST_IDLE, 1'b1, 12'hABC, 1'b0, 15'd0, 12'h375, 15'd1};
        tbl[3] = '{ST_IDLE, 1'b0, 12'h000, 1'b0, 15'd0, 12'h375, 15'd1};
        tbl[4] = '{ST_RX,   1'b0, 12'h000, 1'b0, 15'd0, 12'h375, 15'd1};
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_val(i);

        // Reset state
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single pixel in receive state, then a pixel outside it
        for (int i = 0; i < 5; i++) begin
            set_in(tbl[i].st, tbl[i].v, tbl[i].d, 1'b0, 1'b0, '0);
            step();
            check("tbl_wre", 32'(spram_wre), 32'(tbl[i].e_wre));
            if (tbl[i].e_wre) begin
                check("tbl_addr", 32'(spram_addr), 32'(tbl[i].e_addr));
                check("tbl_wdata", 32'(spram_wr_data), 32'(tbl[i].e_wd));
            end
            check("tbl_wr_addr", 32'(wr_addr), 32'(tbl[i].e_wa));
            check("tbl_ovf", 32'(overflow), 32'd0);
        end

        // Writes starved by a held read: buffer fills, two pixels dropped
        set_in(ST_RX, 1'b0, '0, 1'b1, 1'b0, '0);
        step();
        for (int j = 0; j < 8; j++) begin
            set_in(ST_RX, j < 6, DW'(12'h101 + j), 1'b0, 1'b1, 15'd5);
            step();
            if (j >= 1) begin
                check("hold_rd_valid", 32'(rd_valid), 32'd1);
                check("hold_rd_data", 32'(rd_data), 32'h5A5);
            end
        end
        check("hold_full", 32'(fifo_full), 32'd1);
        check("hold_ovf", 32'(overflow), 32'd1);
        wl_clear();
        set_in(ST_RX, 1'b0, '0, 1'b0, 1'b0, '0);
        repeat (6) step();
        check("drain_count", wl_addr.size(), 32'd4);
        for (int k = 0; k < wl_addr.size() && k < 4; k++) begin
            check("drain_addr", wl_addr[k], k);
            check("drain_data", wl_data[k], 32'h101 + k);
        end

        // Pixels queued behind reads are discarded by a frame restart
        for (int j = 0; j < 3; j++) begin
            set_in(ST_RX, 1'b1, DW'(12'h201 + j), 1'b0, 1'b1, 15'd9);
            step();
        end
        set_in(ST_RX, 1'b0, '0, 1'b1, 1'b0, '0);
        step();
        check("fs_wre", 32'(spram_wre), 32'd0);
        check("fs_wr_addr", 32'(wr_addr), 32'd0);
        check("fs_ovf", 32'(overflow), 32'd0);
        wl_clear();
        set_in(ST_RX, 1'b0, '0, 1'b0, 1'b0, '0);
        repeat (4) step();
        check("fs_no_writes", wl_addr.size(), 32'd0);

        // Frame wrap: nine pixels into an eight-pixel frame
        wl_clear();
        for (int j = 0; j < 9; j++) begin
            set_in(ST_RX, 1'b1, DW'(j + 1), 1'b0, 1'b0, '0);
            step();
        end
        set_in(ST_RX, 1'b0, '0, 1'b0, 1'b0, '0);
        repeat (4) step();
        check("wrap_count", wl_addr.size(), 32'd9);
        done_cnt = 0;
        for (int k = 0; k < wl_addr.size() && k < 9; k++) begin
            check("wrap_addr", wl_addr[k], k % FP);
            check("wrap_data", wl_data[k], k + 1);
            check("wrap_done", wl_done[k], (k == 7) ? 32'd1 : 32'd0);
            done_cnt += wl_done[k];
        end
        check("wrap_done_cnt", done_cnt, 32'd1);

        // Push while full in the same cycle as a pop: no overflow
        for (int j = 0; j < 4; j++) begin
            set_in(ST_RX, 1'b1, DW'(12'h301 + j), 1'b0, 1'b1, 15'd2);
            step();
        end
        check("pp_full_before", 32'(fifo_full), 32'd1);
        set_in(ST_RX, 1'b1, 12'h305, 1'b0, 1'b0, '0);
        step();
        check("pp_full_after", 32'(fifo_full), 32'd1);
        check("pp_ovf", 32'(overflow), 32'd0);
        check("pp_wre", 32'(spram_wre), 32'd1);
        check("pp_wdata", 32'(spram_wr_data), 32'h301);
        check("pp_addr", 32'(spram_addr), 32'd1);
        set_in(ST_RX, 1'b0, '0, 1'b0, 1'b0, '0);
        repeat (6) step();

        // Randomised traffic against the model
        for (int n = 0; n < 600; n++) begin
            set_in(($urandom_range(0, 9) == 0) ? ST_IDLE : ST_RX,
                   $urandom_range(0, 3) != 0, DW'($urandom),
                   $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 40,
                   AW'($urandom_range(0, 15)));
            step();
        end

        // Asynchronous reset in the middle of reads and writes
        for (int j = 0; j < 4; j++) begin
            set_in(ST_RX, 1'b1, DW'(12'h401 + j), 1'b0, 1'b1, 15'd3);
            step();
        end
        check("pre_rst_rd_valid", 32'(rd_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        set_in(8'h00, 1'b0, '0, 1'b0, 1'b0, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_in(ST_RX, 1'b1, 12'h777, 1'b0, 1'b0, '0);
        step();
        set_in(ST_RX, 1'b0, '0, 1'b0, 1'b0, '0);
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/spram_frame_wr_arb.md
Name: spram_frame_wr_arb

Overview:
- Parametrised successor to the single-channel SPRAM write block of the photo-frame design.
- Accepts the received pixel stream (RGB444 by default) while the top FSM is in the receive state.
- Buffers accepted pixels in a small FIFO and writes them to sequential frame-buffer addresses.
- Shares the single-port SPRAM with a display read port; display reads have priority, and writes drain in cycles with no read.

Parameters:
- DW, 12, pixel/data width
- AW, 15, SPRAM address width
- FRAME_PIXELS, 19200, pixels per frame; write address wraps at FRAME_PIXELS-1; must be <= 2**AW
- FIFO_DEPTH, 4, write buffer depth; power of 2, >= 2
- WR_STATE, 8'h02, value of i_state that enables stream capture

Ports:
- i_clk_sys  in  1  system clock; all logic on the rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_state  in  8  top-level FSM state code
- i_rx_valid  in  1  one-cycle strobe; i_rx_data is a valid pixel
- i_rx_data  in  DW  received pixel
- i_frame_start  in  1  one-cycle pulse: restart the frame
- i_rd_req  in  1  display read request, this cycle
- i_rd_addr  in  AW  display read address
- o_rd_valid  out  1  o_rd_data is valid
- o_rd_data  out  DW  display read data
- o_spram_addr  out  AW  SPRAM address
- o_spram_wr_data  out  DW  SPRAM write data
- o_spram_wre  out  1  SPRAM write enable; 0 = read
- i_spram_rd_data  in  DW  SPRAM read data, valid 1 cycle after the read address
- o_wr_addr  out  AW  next frame address to be written
- o_frame_done  out  1  one-cycle pulse after the last pixel of a frame is written
- o_fifo_full  out  1  write FIFO full
- o_overflow  out  1  sticky flag: a pixel was dropped

Behaviour:
- Reset values: all outputs 0; FIFO empty; write address 0.
- Capture (push):
  - Push when i_rx_valid && i_state==WR_STATE && !i_frame_start && (!full || pop this cycle).
  - If i_rx_valid && i_state==WR_STATE && !i_frame_start but full with no pop: drop the pixel and set o_overflow.
  - i_rx_valid in any other state is ignored silently.
- SPRAM port, evaluated per cycle, one access per cycle:
  - i_rd_req=1: o_spram_addr=i_rd_addr, o_spram_wre=0.
  - Else if FIFO not empty: o_spram_addr=o_wr_addr, o_spram_wr_data=FIFO head, o_spram_wre=1; pop the head; increment the write address.
  - Else: o_spram_wre=0, address holds its last value.
  - SPRAM outputs are registered: a request/pop decided in cycle N drives the SPRAM in cycle N+1.
- Read return: o_rd_valid=1 and o_rd_data=i_spram_rd_data exactly 2 cycles after i_rd_req (register stage + SPRAM latency). Back-to-back reads are fully pipelined, one result per cycle.
- Write address: increments per pop. At FRAME_PIXELS-1 it wraps to 0 and o_frame_done pulses for 1 cycle, aligned with the SPRAM write of that last pixel.
- FIFO pass-through latency: pixel on i_rx_valid at cycle N (FIFO empty, no reads) produces o_spram_wre=1 at cycle N+2.
- Simultaneous push and pop when full: both happen, no overflow.
- Writes are starved while i_rd_req stays high. The FIFO fills, then overflow occurs; this is allowed, and flagged via o_overflow.
- i_frame_start:
  - Flushes the FIFO synchronously (pending pixels discarded).
  - Write address -> 0; o_overflow -> 0.
  - Takes priority over a same-cycle push and pop: no SPRAM write is issued that cycle.
  - Does not affect in-flight reads.
- Leaving WR_STATE: the FIFO keeps draining; only new captures stop.
- Asynchronous reset mid-operation: FIFO contents lost, all pipeline registers cleared, o_rd_valid drops immediately.

Decomposition:
- Shared package/header, frame_pkg: FSM state codes (ST_IDLE=8'h01, ST_RX=8'h02), default DW/AW/FRAME_PIXELS constants.
- Sub-module frame_wr_fifo:
  - Synchronous FIFO, parameters DW and FIFO_DEPTH.
  - Ports push, pop, flush, full, empty, head data.
  - Pointers carry an extra wrap bit.
- Top contains the arbiter, address counter, and read-return pipeline.

Test Plan:
- Reset, i_state=8'h02, single pixel 12'h375 -> o_spram_wre=1 two cycles later, o_spram_addr=0, o_spram_wr_data=12'h375, o_wr_addr becomes 1.
- i_state=8'h01, pixel 12'hABC -> no SPRAM write, o_overflow stays 0.
- FRAME_PIXELS=8 override, 9 pixels 12'h001..12'h009 -> addresses 0..7 then 0, o_frame_done pulses once with the write of 12'h008, last write 12'h009 at address 0.
- Hold i_rd_req=1 at i_rd_addr=5 (SPRAM model preloaded 12'h5A5) while streaming 6 pixels, FIFO_DEPTH=4 -> o_rd_valid every cycle with 12'h5A5, o_fifo_full=1, 2 pixels dropped, o_overflow=1; release the read -> 4 writes drain to addresses 0..3.
- 3 pixels queued behind reads, then i_frame_start -> FIFO empty, o_wr_addr=0, o_overflow=0, no write to the SPRAM.
- Push on the same cycle as a pop with the FIFO full -> occupancy unchanged, no overflow; i_rst_n low mid-stream -> all outputs 0 asynchronously.
